// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared defaults, FSM states and test pattern for the RAM BIST
package ram_pkg;

  localparam int DEF_ADDR_SIZE = 10;
  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_MEM_SIZE  = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SET,
    S_WR_STB,
    S_RD,
    S_DONE
  } bist_state_e;

  // Callers truncate to their word width; phase 1 is the bitwise complement.
  function automatic logic [31:0] ram_pattern(input logic [31:0] addr, input logic phase);
    logic [31:0] p;
    p = addr << 1;
    return phase ? ~p : p;
  endfunction

endpackage

// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - single-port RAM bus between the BIST sequencer and the RAM
interface ram_bist_if #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 8
);

  logic [ADDR_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] data_in;
  logic                 wr;
  logic                 cs;
  logic [WORD_SIZE-1:0] data_out;

  modport master (
    output addr,
    output data_in,
    output wr,
    output cs,
    input  data_out
  );

  modport slave (
    input  addr,
    input  data_in,
    input  wr,
    input  cs,
    output data_out
  );

endinterface

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - two-pass write/read-back march over a single-port RAM
module ram_bist
  import ram_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int MEM_SIZE  = DEF_MEM_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE-1:0] fail_addr,
  output logic [WORD_SIZE-1:0] fail_data,
  output logic                 fail_phase,
  ram_bist_if.master           ram
);

  localparam int CNT_W = ADDR_SIZE + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEM_SIZE - 1);

  bist_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic [WORD_SIZE-1:0] data_in_q, data_in_d;
  logic                 wr_q, wr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ADDR_SIZE-1:0] fail_addr_q, fail_addr_d;
  logic [WORD_SIZE-1:0] fail_data_q, fail_data_d;
  logic                 fail_phase_q, fail_phase_d;

  logic [WORD_SIZE-1:0] expected;
  logic                 at_last;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    data_in_d    = data_in_q;
    wr_d         = wr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    fail_phase_d = fail_phase_q;
    expected     = WORD_SIZE'(ram_pattern(32'(cnt_q), phase_q));
    at_last      = (cnt_q >= LAST_ADDR);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_WR_SET;
          cnt_d        = '0;
          phase_d      = 1'b0;
          data_in_d    = WORD_SIZE'(ram_pattern(32'd0, 1'b0));
          wr_d         = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_data_d  = '0;
          fail_phase_d = 1'b0;
        end
      end
      S_WR_SET: begin
        state_d = S_WR_STB;
        wr_d    = 1'b1;
      end
      S_WR_STB: begin
        // Strobe drops on the same edge the next address is presented.
        wr_d = 1'b0;
        if (!at_last) begin
          state_d   = S_WR_SET;
          cnt_d     = cnt_q + 1'b1;
          data_in_d = WORD_SIZE'(ram_pattern(32'(cnt_q) + 32'd1, phase_q));
        end else begin
          state_d = S_RD;
          cnt_d   = '0;
        end
      end
      S_RD: begin
        if (ram.data_out != expected) begin
          state_d      = S_DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          pass_d       = 1'b0;
          fail_addr_d  = cnt_q[ADDR_SIZE-1:0];
          fail_data_d  = ram.data_out;
          fail_phase_d = phase_q;
        end else if (!at_last) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!phase_q) begin
          state_d   = S_WR_SET;
          phase_d   = 1'b1;
          cnt_d     = '0;
          data_in_d = WORD_SIZE'(ram_pattern(32'd0, 1'b1));
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      data_in_q    <= '0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      data_in_q    <= data_in_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      fail_phase_q <= fail_phase_d;
    end
  end

  assign ram.addr    = cnt_q[ADDR_SIZE-1:0];
  assign ram.data_in = data_in_q;
  assign ram.wr      = wr_q;
  assign ram.cs      = busy_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign fail_phase = fail_phase_q;

endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - directed bench for ram_bist with an inline 1024x8 RAM model
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass, fail_phase;
  logic [9:0] fail_addr;
  logic [7:0] fail_data;

  int vectors = 0;
  int miscompares = 0;

  ram_bist_if #(.ADDR_SIZE(10), .WORD_SIZE(8)) bus ();

  ram_bist dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_addr  (fail_addr),
    .fail_data  (fail_data),
    .fail_phase (fail_phase),
    .ram        (bus)
  );

  always #5 clk = ~clk;

  // RAM model; fault_mode 1 reads 0 at addr 300, 2 holds bit 0 low at addr 1023.
  logic [7:0] mem [1024];
  int         fault_mode = 0;
  logic [7:0] rd_word;

  always @(posedge clk) if (bus.cs && bus.wr) mem[bus.addr] <= bus.data_in;

  always_comb begin
    rd_word = mem[bus.addr];
    if (fault_mode == 1 && bus.addr == 10'd300) rd_word = 8'h00;
    if (fault_mode == 2 && bus.addr == 10'd1023) rd_word[0] = 1'b0;
  end
  assign bus.data_out = rd_word;

  logic [9:0] prev_addr = '0;
  logic [7:0] prev_din = '0;

  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (bus.cs !== busy) begin
        miscompares++;
        $display("FAIL cs_eq_busy: cs=%b busy=%b", bus.cs, busy);
      end
      if (bus.wr === 1'b1) begin
        vectors++;
        if (bus.addr !== prev_addr || bus.data_in !== prev_din) begin
          miscompares++;
          $display("FAIL wr_stable: addr=%0d/%0d din=%h/%h while wr=1",
                   bus.addr, prev_addr, bus.data_in, prev_din);
        end
      end
    end
    prev_addr = bus.addr;
    prev_din  = bus.data_in;
  end

  task automatic run_test(input int pulse_at, output int cyc, output int busy_cnt,
                          output logic first_done, output logic first_busy);
    cyc = 0;
    busy_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_done = done;
    first_busy = busy;
    while (!done && cyc < 20000) begin
      if (busy) busy_cnt++;
      start = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, pass, fail_phase, bus.wr, bus.cs} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: busy/done/pass/phase/wr/cs=%b required 000000",
               {busy, done, pass, fail_phase, bus.wr, bus.cs});
    end
    vectors++;
    if (bus.addr !== 10'd0 || bus.data_in !== 8'd0 || fail_addr !== 10'd0 || fail_data !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_values: addr=%0d din=%h fail_addr=%0d fail_data=%h required 0",
               bus.addr, bus.data_in, fail_addr, fail_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_result(input string name, input int cyc, input int exp_cyc,
                              input logic exp_pass, input logic [9:0] exp_addr,
                              input logic [7:0] exp_data, input logic exp_phase);
    vectors++;
    if (cyc !== exp_cyc) begin
      miscompares++;
      $display("FAIL %s_cycles: got %0d required %0d", name, cyc, exp_cyc);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass) begin
      miscompares++;
      $display("FAIL %s_status: done=%b busy=%b pass=%b required 1 0 %b",
               name, done, busy, pass, exp_pass);
    end
    vectors++;
    if (fail_addr !== exp_addr || fail_data !== exp_data || fail_phase !== exp_phase) begin
      miscompares++;
      $display("FAIL %s_fail_info: addr=%0d data=%h phase=%b required %0d %h %b",
               name, fail_addr, fail_data, fail_phase, exp_addr, exp_data, exp_phase);
    end
  endtask

  task automatic test_full_pass();
    int cyc, bc;
    logic fd, fb;
    fault_mode = 0;
    run_test(-1, cyc, bc, fd, fb);
    check_result("full_pass", cyc, 6144, 1'b1, 10'd0, 8'h00, 1'b0);
    vectors++;
    if (bc !== 6144) begin
      miscompares++;
      $display("FAIL full_pass_busy: got %0d required 6144", bc);
    end
    vectors++;
    if (fb !== 1'b1 || fd !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pass_start: busy=%b done=%b required 1 0", fb, fd);
    end
    vectors++;
    if (mem[5] !== 8'hF5 || mem[0] !== 8'hFF || mem[1023] !== 8'h01) begin
      miscompares++;
      $display("FAIL mem_complement: mem5=%h mem0=%h mem1023=%h required f5 ff 01",
               mem[5], mem[0], mem[1023]);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, bc;
    logic fd, fb;
    fault_mode = 0;
    run_test(100, cyc, bc, fd, fb);
    check_result("busy_start", cyc, 6144, 1'b1, 10'd0, 8'h00, 1'b0);
    vectors++;
    if (bc !== 6144) begin
      miscompares++;
      $display("FAIL busy_start_busy: got %0d required 6144", bc);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bc;
    logic fd, fb;
    fault_mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (999) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, pass, bus.wr, bus.cs} !== 5'b0 || bus.addr !== 10'd0 || bus.data_in !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_reset: busy/done/pass/wr/cs=%b addr=%0d din=%h required 0",
               {busy, done, pass, bus.wr, bus.cs}, bus.addr, bus.data_in);
    end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    run_test(-1, cyc, bc, fd, fb);
    check_result("rerun", cyc, 6144, 1'b1, 10'd0, 8'h00, 1'b0);
  endtask

  task automatic test_fail_300();
    int cyc, bc;
    logic fd, fb;
    fault_mode = 1;
    run_test(-1, cyc, bc, fd, fb);
    check_result("fail300", cyc, 2349, 1'b0, 10'd300, 8'h00, 1'b0);
  endtask

  task automatic test_restart_stuck_bit();
    int cyc, bc;
    logic fd, fb;
    fault_mode = 2;
    run_test(-1, cyc, bc, fd, fb);
    vectors++;
    if (fd !== 1'b0 || fb !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_from_done: done=%b busy=%b required 0 1", fd, fb);
    end
    check_result("stuck1023", cyc, 6144, 1'b0, 10'd1023, 8'h00, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_start_while_busy();
    test_reset_mid_run();
    test_fail_300();
    test_restart_stuck_bit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
